// File: rtl/addr_data_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_data_pkg
// Description : Shared defaults, a constant clog2 helper and the {addr,data}
//               beat type for the addr/data stream sink.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_data_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_ADDR_WIDTH = 32;
    localparam int c_DEPTH      = 16;
    localparam int c_ERR_CNT_W  = 16;

    // Ceiling log2 usable in constant expressions (port widths, localparams).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // One beat at the default widths; addr occupies the upper bits so that a
    // packed beat matches the {addr, data} concatenation stored in the FIFO.
    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] data;
    } beat_t;

    function automatic beat_t pack_beat(input logic [c_ADDR_WIDTH-1:0] addr,
                                        input logic [c_DATA_WIDTH-1:0] data);
        beat_t b;
        b.addr = addr;
        b.data = data;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented combinationally from the storage array; there is no
//               empty bypass, so a write becomes visible one cycle later.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_wr_valid/o_wr_ready/i_wr_data - write handshake
//               o_rd_valid/i_rd_ready/o_rd_data - read handshake (FWFT)
//               o_level           - occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
    import addr_data_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [WIDTH-1:0]       i_wr_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [clog2(DEPTH):0]  o_level
);

    localparam int c_PTR_W = clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_level == c_LVL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    // Ready is held low through reset so nothing is written while the
    // pointers are being cleared.
    assign o_wr_ready = !w_full && !rst;
    assign o_rd_valid = !w_empty;
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = o_rd_valid && i_rd_ready;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_level    = r_level;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/addr_data_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : addr_data_stream_sink
// Description : Buffers an incrementing addr/data beat stream in an FWFT FIFO,
//               re-emits it downstream and checks that accepted beats step by
//               +1 on both fields. Gaps and dropped beats raise sticky flags.
// Ports       : sys_clk, sys_rst           - clock, synchronous active-high reset
//               in_valid/in_ready/in_addr/in_data     - upstream handshake
//               out_valid/out_ready/out_addr/out_data - downstream handshake
//               level    - FIFO occupancy 0..DEPTH
//               overflow - sticky, a beat was offered while not ready
//               seq_err  - sticky, a sequence gap was seen
//               err_cnt  - saturating count of gaps
// Revision    : 1.0 - initial release
// ============================================================================
module addr_data_stream_sink
    import addr_data_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DEPTH      = c_DEPTH,
    parameter int ERR_CNT_W  = c_ERR_CNT_W
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic                  seq_err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int c_BEAT_W = ADDR_WIDTH + DATA_WIDTH;

    logic [c_BEAT_W-1:0]   w_rd_beat;
    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_exp_addr;
    logic [DATA_WIDTH-1:0] w_exp_data;
    logic                  w_gap;

    logic                  r_have_ref;
    logic [ADDR_WIDTH-1:0] r_ref_addr;
    logic [DATA_WIDTH-1:0] r_ref_data;
    logic                  r_overflow;
    logic                  r_seq_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    sync_fifo_fwft #(
        .WIDTH (c_BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_wr_valid (in_valid),
        .o_wr_ready (in_ready),
        .i_wr_data  ({in_addr, in_data}),
        .o_rd_valid (out_valid),
        .i_rd_ready (out_ready),
        .o_rd_data  (w_rd_beat),
        .o_level    (level)
    );

    assign out_addr = w_rd_beat[c_BEAT_W-1 -: ADDR_WIDTH];
    assign out_data = w_rd_beat[DATA_WIDTH-1:0];

    // in_ready already carries the reset gating, so this is exactly the
    // FIFO's write condition.
    assign w_push = in_valid && in_ready;

    // Expected values wrap modulo each field width independently.
    assign w_exp_addr = r_ref_addr + ADDR_WIDTH'(1);
    assign w_exp_data = r_ref_data + DATA_WIDTH'(1);
    assign w_gap      = r_have_ref && ((in_addr != w_exp_addr) || (in_data != w_exp_data));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_have_ref <= 1'b0;
            r_ref_addr <= '0;
            r_ref_data <= '0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            // A dropped beat leaves the reference untouched, so the next
            // accepted beat shows up as one gap.
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                // Reload unconditionally so one gap counts as one error.
                r_have_ref <= 1'b1;
                r_ref_addr <= in_addr;
                r_ref_data <= in_data;
                if (w_gap) begin
                    r_seq_err <= 1'b1;
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign overflow = r_overflow;
    assign seq_err  = r_seq_err;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
